// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct codes, FSM states, ALUOp and ALUControl encodings for the multicycle MIPS controller
package mips_ctrl_pkg;
    localparam int STATE_W   = 4;
    localparam int ALUCTRL_W = 3;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;
    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;
endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: maps ALUOp and Funct to the 3-bit ALUControl, flagging unsupported R-type functs
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0]           ALUOp,
    input  logic [5:0]           Funct,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 FunctIllegal
);
    // Fixed add/sub for address and branch math, Funct lookup for R-type
    always_comb begin
        ALUControl   = ALU_ADD;
        FunctIllegal = 1'b0;
        if (ALUOp == ALUOP_SUB)
            ALUControl = ALU_SUB;
        else if (ALUOp == ALUOP_FUNCT) begin
            case (Funct)
                FN_ADD:  ALUControl = ALU_ADD;
                FN_SUB:  ALUControl = ALU_SUB;
                FN_AND:  ALUControl = ALU_AND;
                FN_OR:   ALUControl = ALU_OR;
                FN_SLT:  ALUControl = ALU_SLT;
                default: FunctIllegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing a multicycle MIPS datapath; MEM_WAIT_EN adds MemReady stalls on memory states
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 RST,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Funct,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 PCEn,
    output logic                 IorD,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Illegal,
    output logic [STATE_W-1:0]   State
);
    state_t     r_state;
    state_t     w_next;
    logic       r_is_sw;
    logic       w_ready;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_funct_illegal;
    logic [1:0] w_alu_op;

`ifdef MEM_WAIT_EN
    assign w_ready = MemReady;
`else
    assign w_ready = 1'b1 | MemReady;
`endif

    alu_decoder u_alu_decoder (
        .ALUOp       (w_alu_op),
        .Funct       (Funct),
        .ALUControl  (ALUControl),
        .FunctIllegal(w_funct_illegal)
    );

    // State register; lw/sw choice is captured while the opcode is decoded
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_is_sw <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_is_sw <= (Opcode == OP_SW);
        end
    end

    // Next state and per-state control decode, everything deasserted by default
    always_comb begin
        w_next     = S_FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        w_alu_op   = ALUOP_ADD;
        w_pc_write = 1'b0;
        w_branch   = 1'b0;
        Illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite    = w_ready;
                w_pc_write = w_ready;
                ALUSrcB    = 2'b01;
                w_next     = w_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      Illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = r_is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD   = 1'b1;
                w_next = w_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_next   = w_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                ALUSrcA  = 1'b1;
                w_alu_op = ALUOP_FUNCT;
                Illegal  = w_funct_illegal;
                w_next   = w_funct_illegal ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
                PCSrc    = 2'b01;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc      = 2'b10;
                w_pc_write = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign PCEn  = w_pc_write | (w_branch & Zero);
    assign State = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream against a per-instruction cycle model, scoreboard-checked
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, mw, irw, rdst, m2r, rw, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] alu;
        logic       ill;
    } cw_t;

    logic       clk = 1'b0, RST = 1'b0, Zero = 1'b0, MemReady = 1'b1;
    logic [5:0] Opcode = 6'd0, Funct = 6'd0;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    cw_t        exp_q[$];
    int         errors = 0, checks = 0, cyc = 0;
    logic       cur_rst = 1'b0;
    logic [5:0] cur_op = 6'd0, cur_fn = 6'd0;

    multicycle_ctrl dut (
        .clk(clk), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    function automatic cw_t mk(input logic [3:0] st, input logic pcen, iord, mw, irw, rdst, m2r, rw, srca,
                               input logic [1:0] srcb, pcsrc, input logic [2:0] alu, input logic ill);
        return {st, pcen, iord, mw, irw, rdst, m2r, rw, srca, srcb, pcsrc, alu, ill};
    endfunction

    function automatic logic rz();
        return 1'($urandom % 2);
    endfunction

    function automatic int stalls();
`ifdef MEM_WAIT_EN
        return int'($urandom_range(0, 3));
`else
        return 0;
`endif
    endfunction

    function automatic logic go_ready();
`ifdef MEM_WAIT_EN
        return 1'b1;
`else
        return rz();
`endif
    endfunction

    function automatic void alu_ref(input logic [5:0] fn, output logic [2:0] a, output logic il);
        il = 1'b0;
        case (fn)
            6'b100000: a = 3'b010;
            6'b100010: a = 3'b110;
            6'b100100: a = 3'b000;
            6'b100101: a = 3'b001;
            6'b101010: a = 3'b111;
            default: begin a = 3'b010; il = 1'b1; end
        endcase
    endfunction

    // Scoreboard monitor: one expected control word per clock, sampled mid-cycle
    always @(negedge clk) begin
        cw_t e, a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {State, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, PCSrc, ALUControl, Illegal};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl_word cycle %0d: got st=%0d pcen=%b iord=%b mw=%b irw=%b rdst=%b m2r=%b rw=%b srca=%b srcb=%b pcsrc=%b alu=%b ill=%b, expected st=%0d pcen=%b iord=%b mw=%b irw=%b rdst=%b m2r=%b rw=%b srca=%b srcb=%b pcsrc=%b alu=%b ill=%b",
                         cyc, a.st, a.pcen, a.iord, a.mw, a.irw, a.rdst, a.m2r, a.rw, a.srca, a.srcb, a.pcsrc, a.alu, a.ill,
                         e.st, e.pcen, e.iord, e.mw, e.irw, e.rdst, e.m2r, e.rw, e.srca, e.srcb, e.pcsrc, e.alu, e.ill);
            end
        end
    end

    task automatic step(input cw_t e, input logic rdy, input logic z);
        @(posedge clk);
        #1;
        RST      = cur_rst;
        Opcode   = cur_op;
        Funct    = cur_fn;
        MemReady = rdy;
        Zero     = z;
        exp_q.push_back(e);
    endtask

    task automatic mem(input cw_t stall_w, input cw_t go_w);
        int n;
        n = stalls();
        repeat (n) step(stall_w, 1'b0, rz());
        step(go_w, go_ready(), rz());
    endtask

    task automatic do_reset(input int n);
        cw_t idle_w;
        idle_w  = mk(S_IDLE, 0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0);
        cur_rst = 1'b0;
        repeat (n) step(idle_w, rz(), rz());
        cur_rst = 1'b1;
        step(idle_w, rz(), rz());
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input bit abort_in_memwr);
        logic       ill_op, il;
        logic [2:0] a;
        cw_t        memwr_w;
        cur_op = op;
        cur_fn = fn;
        mem(mk(S_FETCH, 0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0),
            mk(S_FETCH, 1,0,0,1,0,0,0,0, 2'b01, 2'b00, 3'b010, 0));
        ill_op = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
        step(mk(S_DECODE, 0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, ill_op), rz(), rz());
        if (!ill_op) begin
            case (op)
                6'b100011: begin
                    step(mk(S_MEMADR, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0), rz(), rz());
                    mem(mk(S_MEMRD, 0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0),
                        mk(S_MEMRD, 0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0));
                    step(mk(S_MEMWB, 0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b010, 0), rz(), rz());
                end
                6'b101011: begin
                    step(mk(S_MEMADR, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0), rz(), rz());
                    memwr_w = mk(S_MEMWR, 0,1,1,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0);
                    mem(memwr_w, memwr_w);
                    if (abort_in_memwr) begin
                        #5;
                        cur_rst = 1'b0;
                        RST     = 1'b0;
                        #1;
                        checks++;
                        if (MemWrite !== 1'b0 || State !== 4'(S_IDLE)) begin
                            errors++;
                            $display("FAIL async_abort: got MemWrite=%b State=%0d, expected MemWrite=0 State=%0d",
                                     MemWrite, State, S_IDLE);
                        end
                        do_reset(2);
                    end
                end
                6'b000000: begin
                    alu_ref(fn, a, il);
                    step(mk(S_EXECUTE, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, a, il), rz(), rz());
                    if (!il) step(mk(S_ALUWB, 0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b010, 0), rz(), rz());
                end
                6'b000100: step(mk(S_BRANCH, z,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 0), rz(), z);
                6'b001000: begin
                    step(mk(S_ADDIEX, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0), rz(), rz());
                    step(mk(S_ADDIWB, 0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b010, 0), rz(), rz());
                end
                default: step(mk(S_JUMP, 1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b010, 0), rz(), rz());
            endcase
        end
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] fns[5];
        logic [5:0] op, fn;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        do_reset(3);
        run_instr(6'b100011, 6'd0, 1'b0, 0);
        run_instr(6'b000000, 6'b101010, 1'b0, 0);
        run_instr(6'b000000, 6'b000111, 1'b0, 0);
        run_instr(6'b000100, 6'd0, 1'b1, 0);
        run_instr(6'b000100, 6'd0, 1'b0, 0);
        run_instr(6'b111111, 6'd0, 1'b0, 0);
        run_instr(6'b101011, 6'd0, 1'b0, 1);
        run_instr(6'b000010, 6'd0, 1'b0, 0);
        run_instr(6'b001000, 6'd0, 1'b0, 0);
        run_instr(6'b101011, 6'd0, 1'b0, 0);
        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 6'b111111) begin
                op = 6'($urandom);
                if (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
                    op = 6'b111111;
            end
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(op, fn, rz(), ($urandom_range(0, 9) == 0));
        end
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
